// File: rtl/min2_stream_tracker.sv
// Tracks the two smallest unsigned samples of each FRAME_LEN-sample frame arriving over
// a valid/ready stream, and presents {min1, min2} on a registered valid/ready output.
module min2_stream_tracker #(
    parameter int DATA_W    = 4,
    parameter int FRAME_LEN = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_min1,
    output logic [DATA_W-1:0] out_min2
);

    localparam int                CNT_W    = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_LEN - 1);
    localparam logic [DATA_W-1:0] ALL_ONES = '1;

    typedef enum logic {
        COLLECT,
        HOLD
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [DATA_W-1:0] m1, m2, m1_next, m2_next;
    logic [DATA_W-1:0] min1_next, min2_next;
    logic              out_valid_next;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt       <= '0;
            m1        <= ALL_ONES;
            m2        <= ALL_ONES;
            out_valid <= 1'b0;
            out_min1  <= '0;
            out_min2  <= '0;
        end else begin
            cnt       <= cnt_next;
            m1        <= m1_next;
            m2        <= m2_next;
            out_valid <= out_valid_next;
            out_min1  <= min1_next;
            out_min2  <= min2_next;
        end
    end

    // The frame result is taken from the post-update tracker values so the last
    // sample of the frame participates without an extra cycle.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        m1_next        = m1;
        m2_next        = m2;
        out_valid_next = out_valid;
        min1_next      = out_min1;
        min2_next      = out_min2;
        in_ready       = 1'b0;

        case (state)
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_data < m1) begin
                        m2_next = m1;
                        m1_next = in_data;
                    end else if (in_data < m2) begin
                        m2_next = in_data;
                    end
                    cnt_next = cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        min1_next      = m1_next;
                        min2_next      = m2_next;
                        out_valid_next = 1'b1;
                        state_next     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    out_valid_next = 1'b0;
                    cnt_next       = '0;
                    m1_next        = ALL_ONES;
                    m2_next        = ALL_ONES;
                    state_next     = COLLECT;
                end
            end
            default: begin
                state_next = COLLECT;
            end
        endcase
    end

endmodule

// File: tb/tb_min2_stream_tracker.sv
// Self-checking bench for min2_stream_tracker: a reference model pushes expected
// {min1,min2} pairs to a scoreboard queue, popped as the DUT presents each result.
module tb_min2_stream_tracker;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_min1;
    logic [3:0] out_min2;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];

    min2_stream_tracker #(.DATA_W(4), .FRAME_LEN(4)) dut (
        .sys_clk  (clk),
        .sys_rst  (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_min1 (out_min1),
        .out_min2 (out_min2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    // Two smallest by position: global minimum, then minimum of the remaining three.
    function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] c, input logic [3:0] d);
        logic [3:0] s[4];
        logic [3:0] lo1, lo2;
        int         idx;
        s[0] = a; s[1] = b; s[2] = c; s[3] = d;
        lo1 = s[0];
        idx = 0;
        for (int i = 1; i < 4; i++) begin
            if (s[i] < lo1) begin
                lo1 = s[i];
                idx = i;
            end
        end
        lo2 = 4'hF;
        for (int i = 0; i < 4; i++) begin
            if (i != idx && s[i] < lo2) lo2 = s[i];
        end
        return {lo1, lo2};
    endfunction

    task automatic send_sample(input logic [3:0] x);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = x;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            errors++;
            $display("[TB] FAIL send_timeout in_ready=%0b required=1", in_ready);
        end
        @(posedge clk);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 4'($urandom_range(0, 15));
    endtask

    task automatic send_frame(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d);
        exp_q.push_back(model(a, b, c, d));
        send_sample(a);
        send_sample(b);
        send_sample(c);
        send_sample(d);
    endtask

    // Waits (bounded) for out_valid; drops in_valid on the first negedge after the frame.
    task automatic collect_result(output logic got, output logic [7:0] res,
                                  output int waited, output logic rdy);
        got    = 1'b0;
        res    = '0;
        waited = 0;
        rdy    = 1'b1;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got    = 1'b1;
                waited = i;
                res    = {out_min1, out_min2};
                rdy    = in_ready;
            end
            if (i == 1) in_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, out_min1, out_min2, in_ready} !== 10'b0_0000_0000_1) begin
            errors++;
            $display("[TB] FAIL reset_during valid=%0b min1=%0d min2=%0d ready=%0b required 0,0,0,1",
                     out_valid, out_min1, out_min2, in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_min1, out_min2, in_ready} !== 10'b0_0000_0000_1) begin
            errors++;
            $display("[TB] FAIL reset_after valid=%0b min1=%0d min2=%0d ready=%0b required 0,0,0,1",
                     out_valid, out_min1, out_min2, in_ready);
        end
    endtask

    task automatic test_basic();
        logic got, rdy; logic [7:0] res, exp; int waited;
        send_frame(4'd1, 4'd2, 4'd3, 4'd4);
        collect_result(got, res, waited, rdy);
        exp = exp_q.pop_front();
        checks++;
        if (!got || res !== exp) begin
            errors++;
            $display("[TB] FAIL basic_1234 got=%0b min=%0d,%0d required %0d,%0d", got, res[7:4], res[3:0], exp[7:4], exp[3:0]);
        end
        checks++;
        if (waited !== 1) begin
            errors++;
            $display("[TB] FAIL basic_latency waited=%0d required=1", waited);
        end
    endtask

    task automatic test_back_to_back();
        logic got, rdy; logic [7:0] res, exp; int waited;
        send_frame(4'd8, 4'd7, 4'd6, 4'd5);
        collect_result(got, res, waited, rdy);
        exp = exp_q.pop_front();
        checks++;
        if (!got || res !== exp) begin
            errors++;
            $display("[TB] FAIL b2b_frame1 got=%0b min=%0d,%0d required %0d,%0d", got, res[7:4], res[3:0], exp[7:4], exp[3:0]);
        end
        checks++;
        if (rdy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_ready_low in_ready=%0b required=0", rdy);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_ready_back in_ready=%0b out_valid=%0b required 1,0", in_ready, out_valid);
        end
        send_frame(4'd9, 4'd11, 4'd10, 4'd12);
        collect_result(got, res, waited, rdy);
        exp = exp_q.pop_front();
        checks++;
        if (!got || res !== exp || waited !== 1) begin
            errors++;
            $display("[TB] FAIL b2b_frame2 got=%0b waited=%0d min=%0d,%0d required %0d,%0d", got, waited, res[7:4], res[3:0], exp[7:4], exp[3:0]);
        end
    endtask

    task automatic test_duplicates();
        logic got, rdy; logic [7:0] res, exp; int waited;
        send_frame(4'd3, 4'd3, 4'd7, 4'd9);
        collect_result(got, res, waited, rdy);
        exp = exp_q.pop_front();
        checks++;
        if (!got || res !== exp) begin
            errors++;
            $display("[TB] FAIL dup_3379 got=%0b min=%0d,%0d required %0d,%0d", got, res[7:4], res[3:0], exp[7:4], exp[3:0]);
        end
        send_frame(4'd15, 4'd15, 4'd15, 4'd15);
        collect_result(got, res, waited, rdy);
        exp = exp_q.pop_front();
        checks++;
        if (!got || res !== exp) begin
            errors++;
            $display("[TB] FAIL dup_all15 got=%0b min=%0d,%0d required %0d,%0d", got, res[7:4], res[3:0], exp[7:4], exp[3:0]);
        end
    endtask

    task automatic test_backpressure();
        logic got, rdy; logic [7:0] res, exp; int waited;
        @(negedge clk);
        out_ready = 1'b0;
        send_frame(4'd2, 4'd1, 4'd0, 4'd4);
        collect_result(got, res, waited, rdy);
        exp = exp_q.pop_front();
        checks++;
        if (!got || res !== exp) begin
            errors++;
            $display("[TB] FAIL bp_result got=%0b min=%0d,%0d required %0d,%0d", got, res[7:4], res[3:0], exp[7:4], exp[3:0]);
        end
        in_valid = 1'b1;
        in_data  = 4'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || {out_min1, out_min2} !== exp || in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold cycle=%0d valid=%0b min=%0d,%0d ready=%0b required 1,%0d,%0d,0",
                         i, out_valid, out_min1, out_min2, in_ready, exp[7:4], exp[3:0]);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release valid=%0b ready=%0b required 0,1", out_valid, in_ready);
        end
        send_frame(4'd10, 4'd12, 4'd11, 4'd13);
        collect_result(got, res, waited, rdy);
        exp = exp_q.pop_front();
        checks++;
        if (!got || res !== exp) begin
            errors++;
            $display("[TB] FAIL bp_next_frame got=%0b min=%0d,%0d required %0d,%0d", got, res[7:4], res[3:0], exp[7:4], exp[3:0]);
        end
    endtask

    task automatic test_gaps();
        logic got, rdy; logic [7:0] res, exp; int waited;
        exp_q.push_back(model(4'd6, 4'd2, 4'd9, 4'd4));
        send_sample(4'd6);
        idle_cycle();
        idle_cycle();
        send_sample(4'd2);
        idle_cycle();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL gaps_midframe valid=%0b ready=%0b required 0,1", out_valid, in_ready);
        end
        send_sample(4'd9);
        send_sample(4'd4);
        collect_result(got, res, waited, rdy);
        exp = exp_q.pop_front();
        checks++;
        if (!got || res !== exp || waited !== 1) begin
            errors++;
            $display("[TB] FAIL gaps_result got=%0b waited=%0d min=%0d,%0d required %0d,%0d", got, waited, res[7:4], res[3:0], exp[7:4], exp[3:0]);
        end
    endtask

    task automatic test_reset_midframe();
        logic got, rdy; logic [7:0] res, exp; int waited;
        send_sample(4'd0);
        send_sample(4'd1);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_min1, out_min2, in_ready} !== 10'b0_0000_0000_1) begin
            errors++;
            $display("[TB] FAIL reset_mid valid=%0b min1=%0d min2=%0d ready=%0b required 0,0,0,1",
                     out_valid, out_min1, out_min2, in_ready);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_frame(4'd5, 4'd6, 4'd7, 4'd8);
        collect_result(got, res, waited, rdy);
        exp = exp_q.pop_front();
        checks++;
        if (!got || res !== exp || waited !== 1) begin
            errors++;
            $display("[TB] FAIL reset_mid_frame got=%0b waited=%0d min=%0d,%0d required %0d,%0d", got, waited, res[7:4], res[3:0], exp[7:4], exp[3:0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_duplicates();
        test_backpressure();
        test_gaps();
        test_reset_midframe();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
